// File: rtl/cam_pkg.sv
// Shared camera-capture definitions: frame geometry defaults, bus widths, state encodings.
package cam_pkg;

    localparam int H_PIX_DEF   = 160;
    localparam int V_LINES_DEF = 120;
    localparam int AW_DEF      = 15;
    localparam int DW_DEF      = 16;

    typedef enum logic [1:0] {
        ST_WAIT_VS    = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_CAPTURE    = 2'd2
    } cam_state_e;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } cam_phase_e;

endpackage

// File: rtl/cam_sync.sv
// Brings the asynchronous camera bus into the clk domain and finds pclk rising edges.
module cam_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       pclk_i,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    output logic       pe_o,
    output logic       vsync_o,
    output logic       href_o,
    output logic [7:0] data_o
);

    logic [10:0] meta_q;
    logic [10:0] sync_q;
    logic        pclk_dly_q;

    // Two-flop synchronizer on the whole bus, plus one delayed pclk copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            pclk_dly_q <= 1'b0;
        end else begin
            meta_q     <= {pclk_i, vsync_i, href_i, data_i};
            sync_q     <= meta_q;
            pclk_dly_q <= sync_q[10];
        end
    end

    assign pe_o    = sync_q[10] & ~pclk_dly_q;
    assign vsync_o = sync_q[9];
    assign href_o  = sync_q[8];
    assign data_o  = sync_q[7:0];

endmodule

// File: rtl/cam_read.sv
// Camera frame capture: assembles RGB565 pixels from byte pairs and writes them to a frame buffer.
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ST_WAIT_VS    | after reset, wait for vertical blanking (vsync high)
//   ST_WAIT_START | in blanking; start capture on vsync fall if capture_en
//   ST_CAPTURE    | accept byte pairs on pclk edges; vsync rise ends the frame
module cam_read
    import cam_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_en,
    input  logic          pclk,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_LINES - 1);

    logic       pe_s;
    logic       vsync_s;
    logic       href_s;
    logic [7:0] data_s;

    cam_state_e    state_q, state_d;
    cam_phase_e    phase_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          wr_req_q;
    logic          regwrite_q;
    logic          frame_done_q;
    logic          full_q;
    logic          vs_prev_q;
    logic          start_cap;

    cam_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .pclk_i  (pclk),
        .vsync_i (vsync),
        .href_i  (href),
        .data_i  (cam_data),
        .pe_o    (pe_s),
        .vsync_o (vsync_s),
        .href_o  (href_s),
        .data_o  (data_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT_VS;
        else     state_q <= state_d;
    end

    // Next-state logic; capture_en only matters at the vsync falling edge (frame start).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_VS:    if (vsync_s) state_d = ST_WAIT_START;
            ST_WAIT_START: if (vs_prev_q && !vsync_s && capture_en) state_d = ST_CAPTURE;
            ST_CAPTURE:    if (vsync_s) state_d = ST_WAIT_START;
            default:       state_d = ST_WAIT_VS;
        endcase
    end

    assign start_cap = (state_q != ST_CAPTURE) && (state_d == ST_CAPTURE);

    // Byte assembly, write strobe pipeline and address counter.
    // A LO byte accepted in the frame-ending cycle still flows through wr_req_q/regwrite_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_HI;
            addr_q       <= '0;
            data_q       <= '0;
            wr_req_q     <= 1'b0;
            regwrite_q   <= 1'b0;
            frame_done_q <= 1'b0;
            full_q       <= 1'b0;
            vs_prev_q    <= 1'b0;
        end else begin
            vs_prev_q    <= vsync_s;
            frame_done_q <= (state_q == ST_CAPTURE) && vsync_s;
            regwrite_q   <= wr_req_q;
            wr_req_q     <= 1'b0;
            if (start_cap) begin
                addr_q  <= '0;
                full_q  <= 1'b0;
                phase_q <= PH_HI;
            end else begin
                if (regwrite_q) begin
                    if (addr_q == LAST_ADDR) full_q <= 1'b1;
                    else                     addr_q <= addr_q + 1'b1;
                end
                if (state_q != ST_CAPTURE || !href_s) begin
                    phase_q <= PH_HI;
                end else if (pe_s && !full_q) begin
                    if (phase_q == PH_HI) begin
                        data_q[DW-1 -: 8] <= data_s;
                        phase_q           <= PH_LO;
                    end else begin
                        data_q[7:0] <= data_s;
                        phase_q     <= PH_HI;
                        wr_req_q    <= 1'b1;
                    end
                end
            end
        end
    end

    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign regwrite   = regwrite_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_cam_read.sv
// Randomized bench for cam_read against a byte-level frame model.
module tb_cam_read;
    import cam_pkg::*;

    localparam int H_PIX   = 4;
    localparam int V_LINES = 2;
    localparam int AW      = 15;
    localparam int DW      = 16;
    localparam int LAST    = H_PIX * V_LINES - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          capture_en = 1'b1;
    logic          pclk = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          frame_done;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: frame armed by a vsync rise, capturing, byte phase, pending high byte, address.
    bit         m_armed = 0;
    bit         m_cap   = 0;
    bit         m_lo    = 0;
    bit         m_full  = 0;
    logic [7:0] m_hi    = 8'h00;
    int         m_addr  = 0;
    int         exp_fd  = 0;
    int         obs_fd  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    cam_read #(.H_PIX(H_PIX), .V_LINES(V_LINES), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (regwrite)   obs_q.push_back({1'b0, addr_in, data_in});
        if (frame_done) obs_fd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // One camera byte: data set up half a pclk period before the rising edge (clk/pclk = 4).
    task automatic cam_byte(input logic [7:0] b);
        cam_data = b;
        #20 pclk = 1'b1;
        if (m_cap && href && !m_full) begin
            if (!m_lo) begin
                m_hi = b;
                m_lo = 1;
            end else begin
                exp_q.push_back({16'(m_addr), m_hi, b});
                m_lo = 0;
                if (m_addr == LAST) m_full = 1;
                else                m_addr++;
            end
        end
        #20 pclk = 1'b0;
    endtask

    task automatic href_set(input logic v);
        href = v;
        if (!v) m_lo = 0;
        #40;
    endtask

    task automatic vs_high();
        vsync = 1'b1;
        if (m_cap) exp_fd++;
        m_cap   = 0;
        m_armed = 1;
        #400;
    endtask

    task automatic vs_low();
        vsync = 1'b0;
        if (m_armed && capture_en) begin
            m_cap  = 1;
            m_addr = 0;
            m_full = 0;
            m_lo   = 0;
        end
        m_armed = 0;
        #400;
    endtask

    // Send a line of n bytes: mode 0 = index from start, mode 1 = random.
    task automatic send_line(input int n, input int start, input bit rnd);
        href_set(1'b1);
        for (int i = 0; i < n; i++) cam_byte(rnd ? 8'($urandom) : 8'(start + i));
        href_set(1'b0);
    endtask

    task automatic check_writes(input string tag);
        int n;
        #200;
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, "_fd"}, obs_fd, exp_fd);
        obs_q.delete();
        exp_q.delete();
        obs_fd = 0;
        exp_fd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_cap = 0; m_armed = 0; m_lo = 0;
        #1;
        chk("rst_addr", 32'(addr_in), 0);
        chk("rst_data", 32'(data_in), 0);
        chk("rst_regwrite", 32'(regwrite), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        #32 rst = 1'b0;
        #40;
    endtask

    initial begin
        #3;
        do_reset();

        // Single pixel 0xAB,0xCD after a vsync pulse.
        vs_high();
        vs_low();
        chk("busy_cap", 32'(busy), 1);
        href_set(1'b1);
        cam_byte(8'hAB);
        cam_byte(8'hCD);
        href_set(1'b0);
        #100;
        chk("pix_data", 32'(data_in), 32'h0000ABCD);
        chk("pix_addr_next", 32'(addr_in), 1);
        vs_high();
        check_writes("single");

        // Full frame of index bytes, then one extra line that must be dropped.
        vs_low();
        send_line(2 * H_PIX, 0, 0);
        send_line(2 * H_PIX, 2 * H_PIX, 0);
        send_line(2 * H_PIX, 4 * H_PIX, 0);
        #100;
        chk("full_addr_hold", 32'(addr_in), LAST);
        chk("full_data_hold", 32'(data_in), 32'h00000E0F);
        vs_high();
        check_writes("frame");

        // Odd trailing byte is dropped at href low.
        vs_low();
        href_set(1'b1);
        cam_byte(8'h11); cam_byte(8'h22); cam_byte(8'h33);
        href_set(1'b0);
        href_set(1'b1);
        cam_byte(8'h44); cam_byte(8'h55);
        href_set(1'b0);
        vs_high();
        check_writes("odd");

        // capture_en low at frame start: no capture even if raised mid-frame.
        capture_en = 1'b0;
        vs_low();
        send_line(2 * H_PIX, 0, 1);
        chk("busy_dis", 32'(busy), 0);
        capture_en = 1'b1;
        send_line(2 * H_PIX, 0, 1);
        chk("busy_midframe", 32'(busy), 0);
        vs_high();
        check_writes("dis");
        vs_low();
        chk("busy_reen", 32'(busy), 1);
        send_line(2 * H_PIX, 0, 1);
        vs_high();
        check_writes("reen");

        // Reset after three pixels and a half pixel; restart from address 0.
        vs_low();
        send_line(7, 8'h30, 0);
        #100;
        do_reset();
        check_writes("pre_rst");
        vs_low();
        send_line(2 * H_PIX, 0, 1);
        chk("busy_after_rst_nosync", 32'(busy), 0);
        vs_high();
        vs_low();
        send_line(2 * H_PIX, 0, 1);
        vs_high();
        check_writes("post_rst");

        // Random frames: random line counts, lengths (including odd) and bytes.
        for (int f = 0; f < 4; f++) begin
            vs_low();
            for (int l = 0; l < V_LINES + int'($urandom_range(0, 1)); l++)
                send_line($urandom_range(1, 2 * H_PIX + 1), 0, 1);
            vs_high();
            check_writes($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_read.md
CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 Parameter H_PIX, default 160, pixels per line.
REQ-002 Parameter V_LINES, default 120, lines per frame.
REQ-003 Parameter AW, default 15, frame-buffer address width.
REQ-004 Parameter DW, default 16, pixel width (RGB565).
REQ-005 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 capture_en  in  1  high allows capture; sampled only at frame start.
REQ-008 pclk  in  1  camera pixel clock, asynchronous level input, not a clock.
REQ-009 vsync  in  1  camera frame sync, asynchronous; high = vertical blanking.
REQ-010 href  in  1  camera line-valid, asynchronous.
REQ-011 cam_data  in  8  camera byte bus, asynchronous.
REQ-012 addr_in  out  AW  frame-buffer write address.
REQ-013 data_in  out  DW  frame-buffer write data.
REQ-014 regwrite  out  1  frame-buffer write strobe, one clk per pixel.
REQ-015 frame_done  out  1  one-clk pulse at the end of a captured frame.
REQ-016 busy  out  1  high while in CAPTURE.

Function
REQ-017 pclk, vsync, href and cam_data SHALL pass through the same 2-flop synchronizer, then one extra pclk delay flop for edge detection.
REQ-018 A pclk rising edge (pe) SHALL be synchronized-pclk high with the delayed copy low; every byte action SHALL occur only on pe.
REQ-019 FSM states: WAIT_VS (wait for synchronized vsync high), WAIT_START (wait for vsync low), CAPTURE.
REQ-020 WAIT_VS->WAIT_START when vsync=1; WAIT_START->CAPTURE when vsync=0 and capture_en=1; while capture_en=0, the FSM SHALL stay in WAIT_START.
REQ-021 On entry to CAPTURE: addr_in=0, byte phase=HI.
REQ-022 In CAPTURE, on pe with href=1: phase HI latches cam_data into data_in[15:8]; phase LO latches it into data_in[7:0] and asserts regwrite on the next clk for exactly 1 cycle.
REQ-023 Byte phase SHALL toggle on each accepted byte and SHALL return to HI whenever synchronized href=0 (an odd trailing byte is dropped).
REQ-024 addr_in SHALL increment by 1 in the cycle after each regwrite pulse, held stable while regwrite=1.
REQ-025 Last address = H_PIX*V_LINES-1 (19199 by default); after the write to it, further pixels SHALL be dropped and addr_in SHALL hold (no wrap).
REQ-026 In CAPTURE, synchronized vsync rising SHALL pulse frame_done for 1 clk and go to WAIT_START; a pending LO write in the same cycle SHALL still complete.
REQ-027 Latency: regwrite high in the cycle starting 3 clk edges after the edge that first samples pclk high for the second byte.
REQ-028 Correct operation SHALL require clk frequency >= 4x pclk; no check is made.
REQ-029 data_in SHALL hold its last value between writes.

Reset
REQ-030 rst=1 SHALL immediately force: state=WAIT_VS, addr_in=0, data_in=0, regwrite=0, frame_done=0, busy=0, phase=HI, synchronizer flops=0.
REQ-031 Reset mid-frame SHALL discard the partial pixel; capture SHALL restart only after a full vsync high->low sequence.

Structure
REQ-032 H_PIX/V_LINES defaults, AW, DW and the state encoding SHALL live in a shared package or include (cam_pkg), also used by buffer_ram_dp users.
REQ-033 The synchronizer + edge detector SHALL be one sub-module, cam_sync, instantiated once; the FSM and datapath SHALL stay in cam_read.

Verification
REQ-034 Reset, then vsync pulse, href high with bytes 0xAB,0xCD at clk/pclk=4 -> one regwrite, addr_in=0, data_in=0xABCD, then addr_in=1.
REQ-035 Full frame, H_PIX=4, V_LINES=2, byte value = index -> 8 regwrites at addresses 0..7, frame_done once on the next vsync rise.
REQ-036 Three bytes 0x11,0x22,0x33 then href low, then 0x44,0x55 -> writes 0x1122 and 0x4455 only.
REQ-037 Extra line beyond V_LINES -> no regwrite after address 7; addr_in stays 7.
REQ-038 capture_en=0 across a vsync -> no regwrite, busy=0; set it to 1 -> capture starts at the next frame.
REQ-039 rst asserted after 3 pixels -> outputs zero immediately; after release, the next frame writes again from address 0.
